// File: rtl/reg_wb_pkg.sv
// Shared definitions for the register writeback buffer: default widths and
// the buffered entry layout.
package reg_wb_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_wb_fifo.sv
// Two-push / two-pop circular buffer. It keeps entries in program order and
// exposes per-slot occupancy and addresses for the pending-write decode.
module reg_wb_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push0,
  input  logic [ADDR_W-1:0]            push0_addr,
  input  logic [DATA_W-1:0]            push0_data,
  input  logic                         push1,
  input  logic [ADDR_W-1:0]            push1_addr,
  input  logic [DATA_W-1:0]            push1_data,
  input  logic [1:0]                   pop_n,
  input  logic                         flush,
  output logic [ADDR_W-1:0]            peek0_addr,
  output logic [DATA_W-1:0]            peek0_data,
  output logic [ADDR_W-1:0]            peek1_addr,
  output logic [DATA_W-1:0]            peek1_data,
  output logic [CW-1:0]                count,
  output logic [DEPTH-1:0]             slot_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0] slot_addr
);

  typedef logic [PW-1:0] ptr_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t     mem [DEPTH];
  ptr_t       rd_ptr;
  ptr_t       wr_ptr;
  logic [1:0] push_n;
  ptr_t       rd_ptr1;
  ptr_t       push1_slot;

  assign push_n     = {1'b0, push0} + {1'b0, push1};
  assign rd_ptr1    = rd_ptr + ptr_t'(1);
  // When A is absent, B takes the slot A would have used.
  assign push1_slot = push0 ? wr_ptr + ptr_t'(1) : wr_ptr;

  always_ff @(posedge clk) begin
    if (!flush) begin
      if (push0) mem[wr_ptr]     <= '{addr: push0_addr, data: push0_data};
      if (push1) mem[push1_slot] <= '{addr: push1_addr, data: push1_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + ptr_t'(pop_n);
      wr_ptr <= wr_ptr + ptr_t'(push_n);
      count  <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  assign peek0_addr = mem[rd_ptr].addr;
  assign peek0_data = mem[rd_ptr].data;
  assign peek1_addr = mem[rd_ptr1].addr;
  assign peek1_data = mem[rd_ptr1].data;

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    slot_valid = '0;
    slot_addr  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_valid[i] = {1'b0, ptr_t'(i) - rd_ptr} < count;
      slot_addr[i]  = mem[i].addr;
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Writeback buffer between the execution units and a two-write-port register
// file; retires up to two results per cycle and exports a pending bitmap.
module reg_writeback
  import reg_wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [ADDR_W-1:0]    a_addr,
  input  logic [DATA_W-1:0]    a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [ADDR_W-1:0]    b_addr,
  input  logic [DATA_W-1:0]    b_data,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 we,
  output logic [ADDR_W-1:0]    write_addr,
  output logic [DATA_W-1:0]    data,
  output logic                 we2,
  output logic [ADDR_W-1:0]    write_addr2,
  output logic [DATA_W-1:0]    data2,
  output logic [2**ADDR_W-1:0] pending,
  output logic [CW-1:0]        count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]                free;
  logic                         a_fire;
  logic                         b_fire;
  logic [1:0]                   pop_n;
  logic [DEPTH-1:0]             slot_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] slot_addr;

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // Ready depends only on registered count, flush and (for B) a_valid; it
  // never waits on same-cycle retirement, and A is always the older entry.
  assign free    = DEPTH_C - count;
  assign a_ready = !flush && (free >= CW'(1));
  assign b_ready = !flush && ((free >= CW'(2)) || ((free >= CW'(1)) && !a_valid));
  assign a_fire  = a_valid && a_ready;
  assign b_fire  = b_valid && b_ready;

  always_comb begin
    pop_n = 2'd0;
    if (!stall && !flush) begin
      pop_n = (count >= CW'(2)) ? 2'd2 : 2'(count);
    end
  end

  // On a same-address pair the younger write alone must land.
  assign we2 = (pop_n == 2'd2);
  assign we  = (pop_n != 2'd0) && !(we2 && (write_addr == write_addr2));

  reg_wb_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push0      (a_fire),
    .push0_addr (a_addr),
    .push0_data (a_data),
    .push1      (b_fire),
    .push1_addr (b_addr),
    .push1_data (b_data),
    .pop_n      (pop_n),
    .flush      (flush),
    .peek0_addr (write_addr),
    .peek0_data (data),
    .peek1_addr (write_addr2),
    .peek1_data (data2),
    .count      (count),
    .slot_valid (slot_valid),
    .slot_addr  (slot_addr)
  );

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i]) pending[slot_addr[i]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: accepted results queue up in program
// order and are compared against the write ports as they retire.
module tb_reg_writeback;
  import reg_wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = DEF_ADDR_W;
  localparam int DW    = DEF_DATA_W;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            a_valid, a_ready, b_valid, b_ready;
  logic [AW-1:0]   a_addr, b_addr;
  logic [DW-1:0]   a_data, b_data;
  logic            stall, flush;
  logic            we, we2;
  logic [AW-1:0]   write_addr, write_addr2;
  logic [DW-1:0]   data, data2;
  logic [2**AW-1:0] pending;
  logic [CW-1:0]   count;

  int checks = 0;
  int errors = 0;
  wb_entry_t exp_q[$];

  reg_writeback #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .a_addr      (a_addr),
    .a_data      (a_data),
    .b_valid     (b_valid),
    .b_ready     (b_ready),
    .b_addr      (b_addr),
    .b_data      (b_data),
    .stall       (stall),
    .flush       (flush),
    .we          (we),
    .write_addr  (write_addr),
    .data        (data),
    .we2         (we2),
    .write_addr2 (write_addr2),
    .data2       (data2),
    .pending     (pending),
    .count       (count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver: inputs change 1 time unit after the rising edge
  task automatic step(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                      input logic st, input logic fl);
    @(posedge clk);
    #1;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    stall = st; flush = fl;
  endtask

  task automatic idle(input logic st);
    step(1'b0, '0, '0, 1'b0, '0, '0, st, 1'b0);
  endtask

  // scoreboard update at the edge: retire from the head, then enqueue A, B
  int u_n, u_free, u_ret;
  always @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      u_n    = exp_q.size();
      u_free = DEPTH - u_n;
      u_ret  = stall ? 0 : (u_n > 2 ? 2 : u_n);
      for (int k = 0; k < u_ret; k++) void'(exp_q.pop_front());
      if (a_valid && u_free >= 1) exp_q.push_back('{addr: a_addr, data: a_data});
      if (b_valid && (u_free >= 2 || (u_free >= 1 && !a_valid)))
        exp_q.push_back('{addr: b_addr, data: b_data});
    end
  end

  // monitor: compare every output mid-cycle against the scoreboard
  int m_n, m_free, m_ret;
  logic m_we, m_ar, m_br;
  logic [2**AW-1:0] m_pend;
  always @(negedge clk) begin
    if (!rst) begin
      m_n    = exp_q.size();
      m_free = DEPTH - m_n;
      m_ret  = (stall || flush) ? 0 : (m_n > 2 ? 2 : m_n);
      m_ar   = !flush && m_free >= 1;
      m_br   = !flush && (m_free >= 2 || (m_free >= 1 && !a_valid));
      m_pend = '0;
      foreach (exp_q[i]) m_pend[exp_q[i].addr] = 1'b1;
      m_we = (m_ret >= 1);
      if (m_ret == 2 && exp_q[0].addr == exp_q[1].addr) m_we = 1'b0;
      check("count", count, m_n);
      check("pending", pending, m_pend);
      check("a_ready", a_ready, m_ar);
      check("b_ready", b_ready, m_br);
      check("we", we, m_we);
      check("we2", we2, m_ret == 2);
      if (m_we) begin
        check("write_addr", write_addr, exp_q[0].addr);
        check("data", data, exp_q[0].data);
      end
      if (m_ret == 2) begin
        check("write_addr2", write_addr2, exp_q[1].addr);
        check("data2", data2, exp_q[1].data);
      end
    end
  end

  initial begin
    rst = 1'b1;
    a_valid = 0; a_addr = '0; a_data = '0;
    b_valid = 0; b_addr = '0; b_data = '0;
    stall = 0; flush = 0;
    #12 rst = 1'b0;
    @(negedge clk);
    check("rst_count", count, 0);
    check("rst_pending", pending, 0);
    check("rst_we", {we, we2}, 2'b00);
    check("rst_ready", {a_ready, b_ready}, 2'b11);

    // independent pair
    step(1, 5'd3, 32'hAA, 1, 5'd5, 32'hBB, 0, 0);
    idle(0);
    @(negedge clk);
    check("pair_we", {we, we2}, 2'b11);
    check("pair_addr", {write_addr, write_addr2}, {5'd3, 5'd5});
    check("pair_data", {data, data2}, {32'hAA, 32'hBB});
    check("pair_pending", pending, (64'd1 << 3) | (64'd1 << 5));
    idle(0);
    @(negedge clk);
    check("pair_pending_clr", pending, 0);

    // same-address collision
    step(1, 5'd7, 32'd1, 1, 5'd7, 32'd2, 0, 0);
    idle(0);
    @(negedge clk);
    check("coll_we", {we, we2}, 2'b01);
    check("coll_port2", {write_addr2, data2}, {5'd7, 32'd2});
    idle(0);
    @(negedge clk);
    check("coll_count", count, 0);

    // fill under stall, then drain in order
    step(1, 5'd10, 32'h100, 1, 5'd11, 32'h101, 1, 0);
    step(1, 5'd12, 32'h102, 1, 5'd13, 32'h103, 1, 0);
    step(1, 5'd14, 32'h104, 1, 5'd15, 32'h105, 1, 0);
    @(negedge clk);
    check("full_count", count, 4);
    check("full_ready", {a_ready, b_ready}, 2'b00);
    idle(0);
    @(negedge clk);
    check("drain0", {write_addr, write_addr2}, {5'd10, 5'd11});
    idle(0);
    @(negedge clk);
    check("drain1", {write_addr, write_addr2}, {5'd12, 5'd13});
    idle(0);

    // flush with three stalled entries
    step(1, 5'd20, 32'h200, 1, 5'd21, 32'h201, 1, 0);
    step(1, 5'd22, 32'h202, 0, '0, '0, 1, 0);
    step(1, 5'd23, 32'h203, 0, '0, '0, 1, 1);
    @(negedge clk);
    check("flush_ready", a_ready, 0);
    check("flush_we", {we, we2}, 2'b00);
    idle(0);
    @(negedge clk);
    check("flush_count", count, 0);
    check("flush_pending", pending, 0);

    // count = 3: A alone fits, B only when A is idle
    step(1, 5'd1, 32'h301, 1, 5'd2, 32'h302, 1, 0);
    step(1, 5'd0, 32'h303, 0, '0, '0, 1, 0);
    step(1, 5'd4, 32'h304, 1, 5'd5, 32'h305, 1, 0);
    @(negedge clk);
    check("c3_ready_ab", {a_ready, b_ready}, 2'b10);
    idle(1);
    @(negedge clk);
    check("c3_a_count", count, 4);
    idle(0);
    idle(0);
    step(1, 5'd6, 32'h306, 1, 5'd7, 32'h307, 1, 0);
    step(1, 5'd8, 32'h308, 0, '0, '0, 1, 0);
    step(0, '0, '0, 1, 5'd9, 32'h309, 1, 0);
    @(negedge clk);
    check("c3_b_ready", b_ready, 1);
    idle(1);
    @(negedge clk);
    check("c3_b_count", count, 4);
    idle(0);
    idle(0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
    end
    idle(0);
    idle(0);
    idle(0);

    // asynchronous reset with three buffered entries
    step(1, 5'd17, 32'h401, 1, 5'd18, 32'h402, 1, 0);
    step(1, 5'd19, 32'h403, 0, '0, '0, 1, 0);
    idle(1);
    @(negedge clk);
    check("pre_rst_count", count, 3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_count", count, 0);
    check("arst_pending", pending, 0);
    check("arst_we", {we, we2}, 2'b00);
    check("arst_ready", {a_ready, b_ready}, 2'b11);
    stall = 0;
    @(negedge clk);
    rst = 1'b0;
    idle(0);
    idle(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Writeback buffer that sits between the execution units and the two-write-port register file and drives the file's write side. It accepts results from two producers (A: ALU, B: load/multiply) over valid/ready, holds them in order in a small FIFO, and retires up to two per cycle onto write ports 1 and 2. It also exports a pending-write bitmap so issue logic can detect read-after-write hazards on registers not yet written.

## Interface
- DEPTH, 4, buffer entries; power of two, ≥2
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- a_valid / a_ready  in / out  1 / 1  producer A handshake
- a_addr / a_data  in  ADDR_W / DATA_W  producer A destination and result
- b_valid / b_ready  in / out  1 / 1  producer B handshake
- b_addr / b_data  in  ADDR_W / DATA_W  producer B destination and result
- stall  in  1  1 = retire nothing this cycle
- flush  in  1  1 = discard all buffered entries at this edge
- we / write_addr / data  out  1 / ADDR_W / DATA_W  register-file write port 1
- we2 / write_addr2 / data2  out  1 / ADDR_W / DATA_W  register-file write port 2
- pending  out  2**ADDR_W  bit i set while any buffered entry targets register i
- count  out  $clog2(DEPTH)+1  buffered entries

## Operation
- Program order within a cycle: A is older than B. Entries are accepted A first, then B.
- Acceptance: a transfer occurs when valid && ready at the rising edge.
- free = DEPTH − count, computed from registered count only. Same-cycle retirement does not create space.
- a_ready = !flush && free ≥ 1.
- b_ready = !flush && (free ≥ 2 || (free ≥ 1 && !a_valid)).
- Retire: when !stall && !flush, the oldest entry goes to port 1 and the second-oldest to port 2. Retire min(count, 2) entries.
- we = 1 when a head entry is retiring; we2 = 1 when a second entry is retiring.
- Same-address collision: if both retiring entries have the same address, we is forced to 0 and only port 2 (younger) writes. Both entries are still removed.
- Address 0 is an ordinary register; no write suppression applies to it.
- Outputs are combinational from registered FIFO state plus stall/flush. When a port is idle, its address and data outputs hold the slot contents and are don't-care.
- Flush: count → 0, pending → 0. No retirement that cycle; we = we2 = 0. Both readies are 0, so no enqueue occurs.
- pending is the OR of the one-hot decodes of all valid entries, computed from registered state.

## Timing
- Reset values: count = 0, pending = 0, we = we2 = 0, a_ready = b_ready = 1, FIFO pointers = 0.
- Reset is asynchronous and takes effect mid-operation; all buffered entries are lost.
- Latency: an entry accepted at edge N is presented on a port during cycle N+1 at the earliest. The register file is written at edge N+1 if it is among the two oldest and stall = 0.
- Sustained throughput is 2 results per cycle with stall = 0. Count cannot exceed 2 unless stall is used.
- Simultaneous enqueue and retire in one cycle: count_next = count + enq − ret.
- Full (count = DEPTH): both readies are 0; retirement proceeds normally.
- Empty: we = we2 = 0 and pending = 0.
- Pointer wrap-around is modulo DEPTH. Wrap must not reorder entries.

## Structure
- Shared package reg_wb_pkg holds ADDR_W/DATA_W defaults and the wb_entry_t struct {addr, data}.
- One sub-module, reg_wb_fifo: 2-write/2-read circular buffer with push0/push1, pop count 0–2, flush, peek0/peek1 and count.
- The top level holds the ready logic, collision masking and pending decode.

## Test plan
- Reset then idle, counts 0: expect we = we2 = 0, pending = 0 and both readies 1. Then assert rst mid-stream with 3 buffered entries and expect an immediate return to the same values.
- A = (r3, 0xAA), B = (r5, 0xBB) in one cycle: next cycle we = 1, write_addr = 3, data = 0xAA; we2 = 1, write_addr2 = 5, data2 = 0xBB. pending bits 3 and 5 set during that cycle only.
- A = (r7, 1), B = (r7, 2) in one cycle: next cycle we = 0, we2 = 1 with write_addr2 = 7, data2 = 2; count returns to 0.
- Hold stall = 1 with DEPTH = 4 while offering pairs: 2 pairs accepted, then a_ready = b_ready = 0 and count = 4. Release stall: retirement follows 2 per cycle in original order.
- Stall with 3 entries, then pulse flush with a_valid = 1: nothing written, a_ready = 0, count and pending become 0.
- With count = 3 and a_valid = b_valid = 1: A accepted, b_ready = 0. With a_valid = 0 instead, B is accepted.
